// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types for the FIFO read-side arbiter.
package fifo_rd_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NPORT.
module fifo_rd_arbiter_rr_pick #(
    parameter int unsigned  NPORT = 4,
    localparam int unsigned IDW   = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             any,
    output logic [IDW-1:0]   idx
);

    logic [2*NPORT-1:0] dbl;
    logic [NPORT-1:0]   rot;
    logic [IDW:0]       off;
    logic [IDW:0]       sum;

    // rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NPORT-1:0];
        off = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (rot[i]) off = (IDW+1)'(i);
        end
        sum = (IDW+1)'(ptr) + off;
        if (sum >= (IDW+1)'(NPORT)) sum = sum - (IDW+1)'(NPORT);
        idx = sum[IDW-1:0];
        any = |req;
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst scheduler merging NPORT async-FIFO read ports into one valid/ready stream.
module fifo_rd_arbiter #(
    parameter int unsigned  NPORT     = 4,
    parameter int unsigned  DSIZE     = 8,
    parameter int unsigned  BURST_LEN = 4,
    localparam int unsigned IDW       = $clog2(NPORT),
    localparam int unsigned CW        = $clog2(BURST_LEN + 1)
) (
    input  logic                   rclk,
    input  logic                   rrst,
    input  logic [NPORT-1:0]       port_en,
    input  logic [NPORT-1:0]       rempty,
    input  logic [NPORT*DSIZE-1:0] rdata,
    output logic [NPORT-1:0]       rinc,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [DSIZE-1:0]       o_data,
    output logic [IDW-1:0]         o_id,
    output logic                   busy
);

    import fifo_rd_arbiter_pkg::*;

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             o_valid_d;
    logic [DSIZE-1:0] o_data_d;
    logic [IDW-1:0]   o_id_d;
    logic             busy_d;
    logic             pop;
    logic             any;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   gnt_inc;

    fifo_rd_arbiter_rr_pick #(
        .NPORT (NPORT)
    ) u_pick (
        .req (~rempty & port_en),
        .ptr (rr_ptr_q),
        .any (any),
        .idx (pick_idx)
    );

    // explicit wrap keeps non-power-of-2 NPORT correct
    assign gnt_inc = (gnt_q == IDW'(NPORT - 1)) ? '0 : gnt_q + IDW'(1);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        o_valid_d = o_valid;
        o_data_d  = o_data;
        o_id_d    = o_id;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (any) begin
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                pop = !rempty[gnt_q] && port_en[gnt_q] && (!o_valid || o_ready);
                if (pop) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(BURST_LEN - 1)) begin
                        rr_ptr_d = gnt_inc;
                        state_d  = IDLE;
                    end
                end else if (rempty[gnt_q] || !port_en[gnt_q]) begin
                    rr_ptr_d = gnt_inc;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // a pop refills the output register even while the previous word is being taken
        if (pop) begin
            o_valid_d = 1'b1;
            o_data_d  = rdata[int'(gnt_q)*DSIZE +: DSIZE];
            o_id_d    = gnt_q;
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end

        busy_d = (state_d == BURST);
    end

    always_comb begin
        rinc = '0;
        if (!rrst && pop) rinc[gnt_q] = 1'b1;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_id     <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            o_valid  <= o_valid_d;
            o_data   <= o_data_d;
            o_id     <= o_id_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomized scoreboard bench for fifo_rd_arbiter with FIFO environment and burst-level reference model.
module tb_fifo_rd_arbiter;

    localparam int NPORT     = 4;
    localparam int DSIZE     = 8;
    localparam int BURST_LEN = 4;
    localparam int IDW       = 2;

    logic                   rclk = 1'b0;
    logic                   rrst;
    logic [NPORT-1:0]       port_en;
    logic [NPORT-1:0]       rempty;
    logic [NPORT*DSIZE-1:0] rdata;
    logic [NPORT-1:0]       rinc;
    logic                   o_valid;
    logic                   o_ready;
    logic [DSIZE-1:0]       o_data;
    logic [IDW-1:0]         o_id;
    logic                   busy;

    always #5 rclk = ~rclk;

    fifo_rd_arbiter #(.NPORT(NPORT), .DSIZE(DSIZE), .BURST_LEN(BURST_LEN)) dut (
        .rclk(rclk), .rrst(rrst), .port_en(port_en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_id(o_id),
        .busy(busy)
    );

    typedef struct packed {
        logic [DSIZE-1:0] d;
        logic [IDW-1:0]   id;
    } sb_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DSIZE-1:0] fq [NPORT][$];
    logic [NPORT-1:0] pop_flag = '0;
    logic [DSIZE-1:0] seq = '0;
    int               pushed_cnt = 0;

    sb_t exp_q[$];
    int  grant_log[$];
    int  blen_log[$];
    int  pops_cnt[NPORT];
    int  out_cnt = 0;

    bit  m_busy, m_valid, mpop, found;
    int  m_gnt, m_cnt, m_ptr;
    logic [NPORT-1:0] exp_rinc, req;
    bit  prev_valid, prev_ready;
    logic [DSIZE-1:0] prev_data;
    logic [IDW-1:0]   prev_id;
    sb_t e;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NPORT; i++) begin
            rempty[i] = (fq[i].size() == 0);
            rdata[i*DSIZE +: DSIZE] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic push_word(input int p);
        fq[p].push_back(seq);
        seq = seq + 8'd1;
        pushed_cnt++;
    endtask

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic drain(input int budget);
        int n;
        bit done;
        port_en = '1;
        o_ready = 1'b1;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (exp_q.size() == 0) && !busy && !o_valid;
            for (int i = 0; i < NPORT; i++) if (fq[i].size() != 0) done = 0;
        end
        if (!done) chk("drain_timeout", 1, 0);
    endtask

    function automatic int glog(input int idx);
        return (grant_log.size() > idx) ? grant_log[idx] : -1;
    endfunction

    function automatic int blog(input int idx);
        return (blen_log.size() > idx) ? blen_log[idx] : -1;
    endfunction

    // FIFO read side: apply the pops the DUT made at this edge, then update flags and data
    initial forever begin
        @(posedge rclk);
        #1;
        for (int i = 0; i < NPORT; i++)
            if (pop_flag[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        pop_flag = '0;
        refresh();
    end

    // monitor + reference: grants by rotation, bursts of at most BURST_LEN, output scoreboard
    initial forever begin
        @(negedge rclk);
        if (rrst) begin
            m_busy = 0; m_valid = 0; m_ptr = 0; m_cnt = 0; m_gnt = 0;
            exp_q.delete();
            prev_valid = 0; prev_ready = 0;
            pop_flag = '0;
        end else begin
            chk("busy", int'(busy), int'(m_busy));
            chk("o_valid", int'(o_valid), int'(m_valid));
            chk("rinc_onehot0", int'($onehot0(rinc)), 1);
            chk("rinc_while_empty", int'(rinc & rempty), 0);
            if (prev_valid && !prev_ready) begin
                chk("hold_o_data", int'(o_data), int'(prev_data));
                chk("hold_o_id", int'(o_id), int'(prev_id));
            end
            if (o_valid && o_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("o_data", int'(o_data), int'(e.d));
                    chk("o_id", int'(o_id), int'(e.id));
                end
            end
            mpop = 0;
            exp_rinc = '0;
            if (m_busy) begin
                mpop = !rempty[m_gnt] && port_en[m_gnt] && (!m_valid || o_ready);
                if (mpop) exp_rinc[m_gnt] = 1'b1;
            end
            chk("rinc", int'(rinc), int'(exp_rinc));
            for (int i = 0; i < NPORT; i++) if (rinc[i]) pops_cnt[i]++;
            pop_flag = rinc;
            if (mpop) exp_q.push_back({rdata[m_gnt*DSIZE +: DSIZE], IDW'(m_gnt)});
            prev_valid = o_valid; prev_ready = o_ready; prev_data = o_data; prev_id = o_id;

            if (m_busy) begin
                if (mpop) m_cnt++;
                if ((mpop && m_cnt == BURST_LEN) ||
                    (!mpop && (rempty[m_gnt] || !port_en[m_gnt]))) begin
                    blen_log.push_back(m_cnt);
                    m_busy = 0;
                    m_ptr = (m_gnt + 1) % NPORT;
                end
            end else begin
                req = ~rempty & port_en;
                found = 0;
                for (int k = 0; k < NPORT; k++) begin
                    if (!found && req[(m_ptr + k) % NPORT]) begin
                        found = 1;
                        m_gnt = (m_ptr + k) % NPORT;
                    end
                end
                if (found) begin
                    m_busy = 1;
                    m_cnt = 0;
                    grant_log.push_back(m_gnt);
                end
            end
            m_valid = mpop ? 1'b1 : (o_ready ? 1'b0 : m_valid);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int gb, bb, ob, pb, s0, ps, n;
        for (int i = 0; i < NPORT; i++) pops_cnt[i] = 0;
        rrst = 1'b1; port_en = '1; o_ready = 1'b1; rempty = '1; rdata = '0;
        repeat (3) tick();
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rinc", int'(rinc), 0);
        chk("rst_o_data", int'(o_data), 0);
        chk("rst_o_id", int'(o_id), 0);
        rrst = 1'b0;

        // single port with three words, then rr_ptr must sit at 3
        gb = grant_log.size(); bb = blen_log.size(); ps = pops_cnt[2];
        tick();
        repeat (3) push_word(2);
        refresh();
        drain(200);
        chk("t1_grants", grant_log.size() - gb, 1);
        chk("t1_port", glog(gb), 2);
        chk("t1_burst_len", blog(bb), 3);
        chk("t1_pops", pops_cnt[2] - ps, 3);
        gb = grant_log.size();
        tick();
        push_word(0); push_word(3);
        refresh();
        drain(200);
        chk("t1_ptr_first", glog(gb), 3);
        chk("t1_ptr_second", glog(gb + 1), 0);

        // all ports full: strict 0,1,2,3 rotation of full bursts
        tick(); rrst = 1'b1; tick(); tick(); rrst = 1'b0;
        gb = grant_log.size(); bb = blen_log.size(); ob = out_cnt;
        tick();
        for (int i = 0; i < NPORT; i++) repeat (8) push_word(i);
        refresh();
        drain(500);
        for (int j = 0; j < 8; j++) begin
            chk("t2_order", glog(gb + j), j % NPORT);
            chk("t2_burst_len", blog(bb + j), BURST_LEN);
        end
        chk("t2_words", out_cnt - ob, 32);

        // back-pressure after the first word
        gb = grant_log.size(); ps = pops_cnt[1];
        tick();
        repeat (4) push_word(1);
        refresh();
        n = 0;
        while (!o_valid && n < 50) begin tick(); n++; end
        if (!o_valid) chk("t3_valid_timeout", 1, 0);
        o_ready = 1'b0;
        s0 = pops_cnt[1];
        repeat (5) tick();
        chk("t3_stall_pops", pops_cnt[1] - s0, 0);
        o_ready = 1'b1;
        drain(200);
        chk("t3_total_pops", pops_cnt[1] - ps, 4);
        chk("t3_one_grant", grant_log.size() - gb, 1);

        // disabled port 0 never popped; dropping port_en[3] cuts its burst
        port_en = 4'b1110;
        s0 = pops_cnt[0]; ps = pops_cnt[3];
        tick();
        repeat (3) push_word(0);
        repeat (6) push_word(3);
        refresh();
        n = 0;
        while (pops_cnt[3] - ps < 2 && n < 50) begin tick(); n++; end
        if (pops_cnt[3] - ps < 2) chk("t4_pop_timeout", 1, 0);
        port_en[3] = 1'b0;
        bb = blen_log.size();
        repeat (5) tick();
        chk("t4_port0_never", pops_cnt[0] - s0, 0);
        chk("t4_cut_pops", pops_cnt[3] - ps, 2);
        chk("t4_cut_burst", blog(bb), 2);
        chk("t4_idle", int'(busy), 0);
        drain(300);

        // reset with a word in flight; restart from port 0, nothing re-read
        ps = pops_cnt[1];
        tick();
        repeat (8) push_word(1);
        refresh();
        n = 0;
        while (!o_valid && n < 50) begin tick(); n++; end
        if (!o_valid) chk("t5_valid_timeout", 1, 0);
        #1 rrst = 1'b1;
        #1;
        chk("t5_rst_o_valid", int'(o_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_rinc", int'(rinc), 0);
        repeat (2) push_word(0);
        refresh();
        gb = grant_log.size();
        repeat (2) tick();
        rrst = 1'b0;
        n = 0;
        while (grant_log.size() == gb && n < 50) begin tick(); n++; end
        chk("t5_restart_port", glog(gb), 0);
        drain(300);
        chk("t5_port1_pops", pops_cnt[1] - ps, 8);

        // randomized traffic, enables and back-pressure
        ob = out_cnt; pb = pushed_cnt;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NPORT; i++) begin
                if ($urandom_range(0, 99) < 30 && fq[i].size() < 12) push_word(i);
                port_en[i] = ($urandom_range(0, 99) < 90);
            end
            o_ready = ($urandom_range(0, 99) < 75);
            refresh();
        end
        drain(2000);
        chk("rand_words", out_cnt - ob, pushed_cnt - pb);
        chk("rand_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
